// File: rtl/xex_core_arbiter.sv
// Round-robin sharing of one XEX-AES-256 core between two requesters, one sector at a time.
// Optional WAIT watchdog enabled by defining XEX_ARB_WDOG_EN.
module xex_core_arbiter #(
    parameter int MAX_BLOCKS = 256,
    parameter int TIMEOUT    = 1024
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [1:0]   req_valid,
    output logic [1:0]   req_ready,
    input  logic [3:0]   req_mode,
    input  logic [255:0] req_sector,
    input  logic [255:0] req_data,
    input  logic [1:0]   req_last,
    output logic [1:0]   rsp_valid,
    output logic [127:0] rsp_data,
    output logic         aes_in_rdy,
    output logic [1:0]   aes_mode,
    output logic [127:0] aes_sector,
    output logic [127:0] aes_data,
    input  logic         aes_busy,
    input  logic         aes_out_rdy,
    input  logic [127:0] aes_data_out,
    output logic         owner,
    output logic         active,
    output logic         error
);
    localparam int CW = $clog2(MAX_BLOCKS);

    typedef enum logic [1:0] {S_IDLE, S_GRANT, S_ISSUE, S_WAIT} state_t;

    state_t        state, next_state;
    logic          ptr;
    logic [CW-1:0] count;
    logic          last_q;

    logic [1:0]    own_mode;
    logic [127:0]  own_sector, own_data;
    logic          own_valid, own_last, mode_bad;
    logic          win, do_grant, xfer, done, final_blk, overrun, stray, expire;

    always_comb begin
        own_mode   = owner ? req_mode[3:2]      : req_mode[1:0];
        own_sector = owner ? req_sector[255:128] : req_sector[127:0];
        own_data   = owner ? req_data[255:128]   : req_data[127:0];
        own_valid  = owner ? req_valid[1]        : req_valid[0];
        own_last   = owner ? req_last[1]         : req_last[0];
        mode_bad   = !own_mode[1];
    end

    always_comb begin
        next_state = state;
        req_ready  = '0;
        win        = ptr;
        do_grant   = 1'b0;
        xfer       = 1'b0;
        done       = 1'b0;
        stray      = 1'b0;
        case (state)
            S_IDLE: begin
                stray = aes_out_rdy;
                if (req_valid[ptr]) begin
                    win      = ptr;
                    do_grant = 1'b1;
                end else if (req_valid[~ptr]) begin
                    win      = ~ptr;
                    do_grant = 1'b1;
                end
                if (do_grant) next_state = S_GRANT;
            end
            S_GRANT: begin
                stray = aes_out_rdy;
                if (mode_bad) begin
                    req_ready[owner] = 1'b1;
                    next_state       = S_IDLE;
                end else begin
                    next_state = S_ISSUE;
                end
            end
            S_ISSUE: begin
                stray            = aes_out_rdy;
                req_ready[owner] = !aes_busy;
                if (own_valid && !aes_busy) begin
                    xfer       = 1'b1;
                    next_state = S_WAIT;
                end
            end
            S_WAIT: begin
                if (aes_out_rdy) begin
                    done       = 1'b1;
                    next_state = final_blk ? S_IDLE : S_ISSUE;
                end else if (expire) begin
                    next_state = S_IDLE;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    // Block MAX_BLOCKS-1 always closes the sector; without req_last it is a protocol error.
    assign final_blk = last_q || (count == CW'(MAX_BLOCKS - 1));
    assign overrun   = done && !last_q && (count == CW'(MAX_BLOCKS - 1));

`ifdef XEX_ARB_WDOG_EN
    localparam int WW = $clog2(TIMEOUT + 1);
    logic [WW-1:0] wd;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                  wd <= '0;
        else if (state != S_WAIT) wd <= '0;
        else if (!expire)         wd <= wd + WW'(1);
    end

    // A result arriving on the expiry cycle takes precedence over the timeout.
    assign expire = (state == S_WAIT) && !aes_out_rdy && (wd == WW'(TIMEOUT - 1));
`else
    logic wd_unused;
    assign wd_unused = ^TIMEOUT;
    assign expire    = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= next_state;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr        <= 1'b0;
            owner      <= 1'b0;
            active     <= 1'b0;
            count      <= '0;
            last_q     <= 1'b0;
            aes_mode   <= '0;
            aes_sector <= '0;
            aes_data   <= '0;
            aes_in_rdy <= 1'b0;
            rsp_data   <= '0;
            rsp_valid  <= '0;
            error      <= 1'b0;
        end else begin
            aes_in_rdy <= xfer;
            rsp_valid  <= '0;
            error      <= stray || overrun || expire || (state == S_GRANT && mode_bad);
            if (do_grant) begin
                owner  <= win;
                active <= 1'b1;
            end
            if (state == S_GRANT) begin
                if (mode_bad) begin
                    active <= 1'b0;
                    ptr    <= ~owner;
                end else begin
                    aes_mode   <= own_mode;
                    aes_sector <= own_sector;
                end
            end
            if (xfer) begin
                aes_data <= own_data;
                last_q   <= own_last;
            end
            if (done) begin
                rsp_data         <= aes_data_out;
                rsp_valid[owner] <= 1'b1;
                if (final_blk) begin
                    count  <= '0;
                    active <= 1'b0;
                    ptr    <= ~owner;
                end else begin
                    count <= count + CW'(1);
                end
            end
            if (expire) begin
                count  <= '0;
                active <= 1'b0;
                ptr    <= ~owner;
            end
        end
    end
endmodule
